syncram_fifo_ctrl: RTL and testbench
====================================

# syncram_fifo_ctrl

First-in-first-out controller that turns the single-port-priority 16 x 8 synchronous RAM (`syncram`) into a 16-deep, 8-bit FIFO. It sits directly upstream of `syncram`, drives all of that RAM's write and read ports, and arbitrates producer pushes against consumer pops. The RAM cannot complete a write and a read in the same cycle, so the controller serialises them. Read data comes back through the RAM's registered `dout` and is re-registered here.

## Interface
Parameters: none. Depth is 16 and width is 8, both fixed by `syncram`.

Ports:
- `clk` in 1 — single clock. Shared with `syncram`.
- `rst` in 1 — synchronous, active-high reset. Also drives `syncram.rst`.
- `push` in 1 — producer requests a write of `push_data`.
- `push_data` in 8 — data to enqueue.
- `push_ack` out 1 — combinational; high when the push is accepted this cycle.
- `pop` in 1 — consumer requests a dequeue.
- `pop_ack` out 1 — combinational; high when the pop is accepted this cycle.
- `rd_data` out 8 — registered dequeued byte. Holds its value until the next dequeue.
- `rd_valid` out 1 — registered one-cycle pulse; `rd_data` is new this cycle.
- `full` out 1 — registered; high when count == 16.
- `empty` out 1 — registered; high when count == 0.
- `count` out 5 — registered occupancy, 0..16.
- `ram_we` out 1 — to `syncram.we`.
- `ram_re` out 1 — to `syncram.re`.
- `ram_waddr` out 4 — to `syncram.waddr`; equals wptr.
- `ram_raddr` out 4 — to `syncram.raddr`; equals rptr.
- `ram_din` out 8 — to `syncram.din`; equals `push_data`.
- `ram_dout` in 8 — from `syncram.dout`.

## Operation
- **State:**
  - wptr and rptr, 4 bits each, wrapping 15 -> 0.
  - count, 5 bits.
  - last_grant, 1 bit: 0 = push won last contention, 1 = pop won.
  - cap_pend, 1 bit: a pop was issued last cycle.
- **Eligibility:**
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
- **Arbitration:**
  - Only one of push and pop is granted per cycle.
  - If exactly one is eligible, it is granted.
  - If both are eligible, the side that did not win the previous contention is granted: pop when last_grant = 0, push when last_grant = 1. last_grant is then updated.
  - last_grant changes only on contention cycles.
- **RAM drive:**
  - `ram_we` = push_ack.
  - `ram_re` = ~ram_we at all times, including idle and reset.
  - This rule is mandatory. `syncram` with we = re = 0 copies mem[raddr] into mem[waddr] and corrupts the queue.
- **Push grant:** at the clock edge, mem[wptr] <= push_data, wptr += 1, count += 1.
- **Pop grant:** `ram_raddr` = rptr. At the edge, the RAM loads dout and the controller sets rptr += 1, count -= 1, cap_pend <= 1.
- **Capture:** in the cycle with cap_pend = 1, rd_data <= ram_dout and rd_valid <= 1 at the edge. Otherwise rd_valid <= 0 and rd_data holds.
- **Idle cycles:** reads with `ram_re` = 1 change `ram_dout`, but they are never captured.
- **Flags:**
  - full = (count_next == 16), registered.
  - empty = (count_next == 0), registered.
  - count never wraps; eligibility gating guarantees this.

## Timing
- **Reset values:**
  - wptr = rptr = 0, count = 0.
  - empty = 1, full = 0.
  - rd_data = 0x00, rd_valid = 0.
  - last_grant = 0, cap_pend = 0.
  - During rst: `ram_we` = 0, `ram_re` = 1, `push_ack` = `pop_ack` = 0.
- **Push:** data is in RAM one edge after push_ack. It can be popped in the very next cycle; there is no bypass hazard.
- **Pop latency:** pop_ack in cycle N, then `ram_dout` valid in cycle N+1, then rd_valid = 1 with rd_data in cycle N+2.
- **Throughput:** back-to-back pops give one rd_valid per cycle. Contended traffic alternates push and pop, half rate each.
- **Full:** push is refused (push_ack = 0) and pop is still served. A pop makes full = 0 on the following cycle.
- **Empty:** pop is refused. A push makes empty = 0 on the following cycle.
- **Wrap:** after 16 pushes, wptr = 0 again. The 17th push is refused while full.
- **Reset mid-operation:** a pending capture is dropped and rd_valid stays 0. `syncram` clears its contents in the same cycle.

## Test plan
- **Reset:** assert rst for 2 cycles with push = pop = 1 -> empty = 1, full = 0, count = 0, rd_valid = 0, rd_data = 0, no acks, `ram_re` = 1.
- **Fill and drain:** push 0x10..0x1F on 16 consecutive cycles -> full = 1 and count = 16 after the 16th edge. A 17th push with 0xAA gets push_ack = 0. Then 16 pops -> rd_data = 0x10..0x1F in order, each rd_valid 2 cycles after its pop_ack. empty = 1 at the end.
- **Contention:** with count = 4, hold push and pop high for 6 cycles -> grants alternate pop, push, pop, push, pop, push. count stays 4 ± 1. `ram_we` and `ram_re` are never both 0 and never both 1.
- **Wrap-around:** push 12 and pop 12, then push 8 (0x80..0x87) -> `ram_waddr` wraps 15 -> 0. Pops return 0x80..0x87 in order.
- **Reset mid-pop:** with count = 3, pop in cycle N and rst in cycle N+1 -> no rd_valid in N+2, count = 0, empty = 1.
- **Idle integrity:** push 0x5A, idle 10 cycles with random `push_data`, then pop -> rd_data = 0x5A.

Source files
------------

// File: rtl/syncram_fifo_ctrl.sv
// 16 x 8 FIFO controller in front of the single-port-priority syncram.
// Pushes and pops are serialised; read data is re-registered one cycle after the RAM.
module syncram_fifo_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       push_ack,
  input  logic       pop,
  output logic       pop_ack,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       ram_we,
  output logic       ram_re,
  output logic [3:0] ram_waddr,
  output logic [3:0] ram_raddr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  logic [3:0] wptr;
  logic [3:0] rptr;
  logic       last_grant;
  logic       cap_pend;
  logic       push_ok;
  logic       pop_ok;
  logic [4:0] count_next;

  // On contention the side that lost last time wins; last_grant = 1 means pop won.
  always_comb begin
    push_ok    = push & ~full & ~rst;
    pop_ok     = pop & ~empty & ~rst;
    push_ack   = push_ok & (~pop_ok | last_grant);
    pop_ack    = pop_ok & (~push_ok | ~last_grant);
    count_next = count;
    if (push_ack)
      count_next = count + 5'd1;
    else if (pop_ack)
      count_next = count - 5'd1;
  end

  // The RAM must never see we = re = 0, or it copies mem[raddr] over mem[waddr].
  assign ram_we    = push_ack;
  assign ram_re    = ~push_ack;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;
  assign ram_din   = push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= 4'd0;
      rptr       <= 4'd0;
      count      <= 5'd0;
      full       <= 1'b0;
      empty      <= 1'b1;
      last_grant <= 1'b0;
      cap_pend   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
    end else begin
      if (push_ack)
        wptr <= wptr + 4'd1;
      if (pop_ack)
        rptr <= rptr + 4'd1;
      count <= count_next;
      full  <= (count_next == 5'd16);
      empty <= (count_next == 5'd0);
      if (push_ok && pop_ok)
        last_grant <= pop_ack;
      // RAM dout is valid the cycle after a pop; capture it then.
      cap_pend <= pop_ack;
      rd_valid <= cap_pend;
      if (cap_pend)
        rd_data <= ram_dout;
    end
  end

endmodule

// File: tb/tb_syncram_fifo_ctrl.sv
// Scoreboard bench for syncram_fifo_ctrl with a behavioural syncram model attached.
// Directed stimulus queues expected pop data; a negedge monitor checks each rd_valid.
module tb_syncram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       push_ack;
  logic       pop;
  logic       pop_ack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ram_we;
  logic       ram_re;
  logic [3:0] ram_waddr;
  logic [3:0] ram_raddr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   assertions = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   exp_count  = 0;
  logic [7:0] mem [16];

  syncram_fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_ack  (push_ack),
    .pop       (pop),
    .pop_ack   (pop_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // syncram: write wins, else read, and with neither it copies mem[raddr] into mem[waddr].
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      ram_dout <= 8'h00;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_din;
    end else if (ram_re) begin
      ram_dout <= mem[ram_raddr];
    end else begin
      mem[ram_waddr] <= mem[ram_raddr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("we_re_exclusive", 32'(ram_we ^ ram_re), 32'd1);
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        checkOutput("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rd_data", 32'(rd_data), 32'(e.data));
        checkOutput("rd_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic applyStimulus(input bit p, input logic [7:0] d, input bit q,
                               input bit epa, input bit eqa, input bit capture,
                               input logic [7:0] edata, input int ewaddr);
    push      = p;
    push_data = d;
    pop       = q;
    @(negedge clk);
    checkOutput("push_ack", 32'(push_ack), 32'(epa));
    checkOutput("pop_ack", 32'(pop_ack), 32'(eqa));
    checkOutput("count", 32'(count), 32'(exp_count));
    checkOutput("full", 32'(full), 32'(exp_count == 16));
    checkOutput("empty", 32'(empty), 32'(exp_count == 0));
    if (ewaddr >= 0)
      checkOutput("ram_waddr", 32'(ram_waddr), 32'(ewaddr));
    if (eqa && capture)
      sb.push_back('{edata, cyc + 2});
    exp_count = exp_count + int'(epa) - int'(eqa);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int n);
    rst  = 1'b1;
    push = 1'b1;
    pop  = 1'b1;
    push_data = 8'hEE;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("rst_push_ack", 32'(push_ack), 32'd0);
      checkOutput("rst_pop_ack", 32'(pop_ack), 32'd0);
      checkOutput("rst_ram_re", 32'(ram_re), 32'd1);
      checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    exp_count = 0;
    @(negedge clk);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic doPush(input logic [7:0] d, input bit epa, input int ewaddr);
    applyStimulus(1'b1, d, 1'b0, epa, 1'b0, 1'b0, 8'h00, ewaddr);
  endtask

  task automatic doPop(input logic [7:0] edata);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, edata, -1);
  endtask

  task automatic doIdle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
  endtask

  initial begin
    applyReset(2);

    $display("[TB] fill and drain");
    for (int i = 0; i < 16; i++) doPush(8'(8'h10 + i), 1'b1, i);
    doPush(8'hAA, 1'b0, -1);
    for (int i = 0; i < 16; i++) doPop(8'(8'h10 + i));
    doIdle(3);

    $display("[TB] contention");
    for (int i = 0; i < 4; i++) doPush(8'(8'h20 + i), 1'b1, -1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 8'(8'h30 + i), 1'b1, (i % 2) == 1, (i % 2) == 0,
                    1'b1, 8'(8'h20 + i / 2), -1);
    doPop(8'h23);
    doPop(8'h31);
    doPop(8'h33);
    doPop(8'h35);
    doIdle(3);

    $display("[TB] wrap-around");
    applyReset(1);
    for (int i = 0; i < 12; i++) doPush(8'(8'h40 + i), 1'b1, i);
    for (int i = 0; i < 12; i++) doPop(8'(8'h40 + i));
    for (int i = 0; i < 8; i++) doPush(8'(8'h80 + i), 1'b1, (12 + i) % 16);
    for (int i = 0; i < 8; i++) doPop(8'(8'h80 + i));
    doIdle(3);

    $display("[TB] reset mid-pop");
    for (int i = 0; i < 3; i++) doPush(8'(8'h60 + i), 1'b1, -1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    applyReset(1);
    doIdle(2);

    $display("[TB] idle integrity");
    doPush(8'h5A, 1'b1, -1);
    doIdle(10);
    doPop(8'h5A);
    doIdle(3);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
